// File: rtl/post_proc_pkg.sv
// post_proc_pkg: shared types and constants for the
// post-processing frame sequencer.
package post_proc_pkg;

    localparam int PIX_W      = 8;
    localparam int COORD_W    = 10;
    localparam int ROW_SZ_DEF = 320;
    localparam int COL_SZ_DEF = 240;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_PUSH,
        S_FLUSH,
        S_DONE
    } state_e;

endpackage

// File: rtl/post_proc_seq_raster_ctr.sv
// raster_ctr: x/y/linear-address counter in raster order,
// wrapping to (0,0) after the last pixel of a frame.
module raster_ctr
    import post_proc_pkg::*;
#(
    parameter int ROW_SZ = ROW_SZ_DEF,
    parameter int COL_SZ = COL_SZ_DEF,
    parameter int ADDR_W = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  lin,
    output logic               last
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0]  lin_q, lin_d;
    logic               x_end, y_end;

    // next position: clear wins, otherwise step one pixel in raster order
    always_comb begin
        x_end = (x_q == COORD_W'(ROW_SZ - 1));
        y_end = (y_q == COORD_W'(COL_SZ - 1));
        x_d   = x_q;
        y_d   = y_q;
        lin_d = lin_q;
        if (clr) begin
            x_d   = '0;
            y_d   = '0;
            lin_d = '0;
        end else if (adv) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            lin_d = (x_end && y_end) ? '0 : lin_q + 1'b1;
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            lin_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            lin_q <= lin_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign lin  = lin_q;
    assign last = x_end && y_end;

endmodule

// File: rtl/post_proc_seq.sv
// post_proc_seq: streams one frame from memory through the median
// filter and writes results back. Option: POST_PROC_SEQ_PERF_EN.
module post_proc_seq
    import post_proc_pkg::*;
#(
    parameter int ROW_SZ    = ROW_SZ_DEF,
    parameter int COL_SZ    = COL_SZ_DEF,
    parameter int ADDR_W    = 17,
    parameter int FLUSH_LEN = 2 * ROW_SZ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic [PIX_W-1:0]   rd_data,
    output logic               flt_reset,
    output logic [PIX_W-1:0]   flt_val,
    output logic [COORD_W-1:0] flt_x,
    output logic [COORD_W-1:0] flt_y,
    output logic               flt_valid,
    input  logic [PIX_W-1:0]   flt_out_val,
    input  logic [COORD_W-1:0] flt_out_x,
    input  logic [COORD_W-1:0] flt_out_y,
    input  logic               flt_out_valid,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    input  logic               wr_ready
`ifdef POST_PROC_SEQ_PERF_EN
    ,
    output logic [23:0]        stall_cycles
`endif
);

    localparam int FCW = $clog2(FLUSH_LEN + 1);

    state_e             state_q, state_d;
    logic               err_q, err_d;
    logic               fin_q, fin_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic               clr, adv, push, last, fin_set;
    logic [COORD_W-1:0] x, y;
    logic [ADDR_W-1:0]  lin;

    raster_ctr #(
        .ROW_SZ (ROW_SZ),
        .COL_SZ (COL_SZ),
        .ADDR_W (ADDR_W)
    ) u_rd_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .adv   (adv),
        .x     (x),
        .y     (y),
        .lin   (lin),
        .last  (last)
    );

    // write-back path; once the last pixel lands, wrapped dummies are dropped
    always_comb begin
        wr_addr = ADDR_W'(flt_out_y) * ADDR_W'(ROW_SZ)
                + ADDR_W'(flt_out_x);
        wr_data = flt_out_val;
        wr_en   = flt_out_valid & wr_ready & busy & ~fin_q;
        fin_set = wr_en
                && (flt_out_x == COORD_W'(ROW_SZ - 1))
                && (flt_out_y == COORD_W'(COL_SZ - 1));
    end

    // frame sequencing: next state, strobes and datapath updates
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        fin_d     = fin_q | fin_set;
        pix_d     = pix_q;
        fcnt_d    = fcnt_q;
        clr       = 1'b0;
        adv       = 1'b0;
        push      = 1'b0;
        rd_req    = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        flt_reset = (state_q == S_CLR);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    err_d   = 1'b0;
                    fin_d   = 1'b0;
                    fcnt_d  = '0;
                    clr     = 1'b1;
                end
            end
            S_CLR: state_d = S_RD;
            S_RD: begin
                rd_req = wr_ready;
                if (wr_ready && rd_ack) begin
                    pix_d   = rd_data;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (wr_ready) begin
                    push    = 1'b1;
                    adv     = 1'b1;
                    state_d = last ? S_FLUSH : S_RD;
                end
            end
            S_FLUSH: begin
                if (fin_q) begin
                    state_d = S_DONE;
                end else if (wr_ready) begin
                    push   = 1'b1;
                    adv    = 1'b1;
                    fcnt_d = fcnt_q + 1'b1;
                    if (fin_set) begin
                        state_d = S_DONE;
                    end else if (fcnt_q == FCW'(FLUSH_LEN - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
            pix_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
            pix_q   <= pix_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign err       = err_q;
    assign rd_addr   = lin;
    assign flt_valid = push;
    assign flt_val   = (state_q == S_FLUSH) ? '0 : pix_q;
    assign flt_x     = x;
    assign flt_y     = y;

`ifdef POST_PROC_SEQ_PERF_EN
    logic [23:0] stall_q, stall_d;

    // stall accounting: back-pressure or a read still waiting for its ack
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE) begin
            if (start) stall_d = '0;
        end else if ((!wr_ready || (state_q == S_RD && !rd_ack))
                     && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // stall counter register
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule
